// File: rtl/semaforo_pkg.sv
// Shared light codes, state encodings and timer width for the intersection scheduler.
// Pure definitions: no latency, no backpressure.
package semaforo_pkg;

  localparam int TIMER_W = 8;

  localparam logic [1:0] GREEN  = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] RED    = 2'd2;

  typedef enum logic [2:0] {
    AG   = 3'd0,
    AY   = 3'd1,
    AR   = 3'd2,
    BG   = 3'd3,
    BY   = 3'd4,
    BR   = 3'd5,
    WALK = 3'd6
  } state_e;

  // A green may end once its minimum has elapsed and something competes for the
  // crossing; its own traffic can extend it only up to the maximum.
  function automatic logic green_done(input logic [TIMER_W-1:0] t,
                                      input logic               own_req,
                                      input logic               other_req,
                                      input logic [TIMER_W-1:0] min_m1,
                                      input logic [TIMER_W-1:0] max_m1);
    return (t >= min_m1) && other_req && (!own_req || (t >= max_m1));
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating tick counter for the time spent in the current phase; clear has priority.
// Count visible one clk after the tick edge; no backpressure.
module phase_timer
  import semaforo_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               tick,
  output logic [TIMER_W-1:0] cnt
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/semaforo_scheduler.sv
// Two-road phase scheduler; Moore outputs change on the clk edge that takes a qualifying tick, no backpressure.
// Pedestrian WALK phase, ped_wait and walk exist only when SEMAFORO_PED_EN is defined.
module semaforo_scheduler
  import semaforo_pkg::*;
#(
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       TA,
  input  logic       TB,
  input  logic       ped_req,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  localparam logic [TIMER_W-1:0] GMIN_M1   = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] GMAX_M1   = TIMER_W'(GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] YELLOW_M1 = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] ALLRED_M1 = TIMER_W'(ALLRED_T - 1);

  state_e             state_q;
  state_e             state_d;
  logic [TIMER_W-1:0] timer;
  logic               ped_pend;

  phase_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_d != state_q),
    .tick  (tick),
    .cnt   (timer)
  );

`ifdef SEMAFORO_PED_EN
  localparam logic [TIMER_W-1:0] WALK_M1 = TIMER_W'(WALK_T - 1);

  logic ped_wait_q;
  logic ped_wait_d;
  logic next_b_q;
  logic next_b_d;

  // Entering WALK serves the request, so the clear beats a coincident press.
  always_comb begin
    ped_wait_d = ped_wait_q;
    if ((state_d == WALK) && (state_q != WALK)) begin
      ped_wait_d = 1'b0;
    end else if (ped_req && (state_q != WALK)) begin
      ped_wait_d = 1'b1;
    end
  end

  always_comb begin
    next_b_d = next_b_q;
    if ((state_d == AR) && (state_q != AR)) begin
      next_b_d = 1'b1;
    end else if ((state_d == BR) && (state_q != BR)) begin
      next_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_wait_q <= 1'b0;
      next_b_q   <= 1'b0;
    end else begin
      ped_wait_q <= ped_wait_d;
      next_b_q   <= next_b_d;
    end
  end

  assign ped_pend = ped_wait_q;
  assign ped_wait = ped_wait_q;
  assign walk     = (state_q == WALK);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pend       = 1'b0;
  assign ped_wait       = 1'b0;
  assign walk           = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= AG;
    end else begin
      state_q <= state_d;
    end
  end

  // Exits are judged only on tick, against the count before this tick is added.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        AG: if (green_done(timer, TA, TB || ped_pend, GMIN_M1, GMAX_M1)) state_d = AY;
        AY: if (timer == YELLOW_M1) state_d = AR;
        AR: if (timer == ALLRED_M1) state_d = ped_pend ? WALK : BG;
        BG: if (green_done(timer, TB, TA || ped_pend, GMIN_M1, GMAX_M1)) state_d = BY;
        BY: if (timer == YELLOW_M1) state_d = BR;
        BR: if (timer == ALLRED_M1) state_d = ped_pend ? WALK : AG;
`ifdef SEMAFORO_PED_EN
        WALK: if (timer == WALK_M1) state_d = next_b_q ? BG : AG;
`endif
        default: state_d = AG;
      endcase
    end
  end

  always_comb begin
    LA = RED;
    LB = RED;
    case (state_q)
      AG:      LA = GREEN;
      AY:      LA = YELLOW;
      BG:      LB = GREEN;
      BY:      LB = YELLOW;
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_semaforo_scheduler.sv
// Directed scenarios push expected observations; a monitor compares them after each strobed clk edge.
module tb_semaforo_scheduler;
  import semaforo_pkg::*;

  logic       clk = 1'b0;
  logic       reset, tick, TA, TB, ped_req;
  logic [1:0] LA, LB;
  logic       walk, ped_wait;
  logic [2:0] phase;

  typedef struct packed {
    logic [2:0] ph;
    logic [1:0] la;
    logic [1:0] lb;
    logic       wk;
    logic       pw;
  } obs_t;

  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  mon_vld = 1'b0;
  string scen = "init";

  always #5 clk = ~clk;

  semaforo_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .TA       (TA),
    .TB       (TB),
    .ped_req  (ped_req),
    .LA       (LA),
    .LB       (LB),
    .walk     (walk),
    .ped_wait (ped_wait),
    .phase    (phase)
  );

  // Expected lamp codes straight from the state/output table.
  function automatic obs_t mk(input state_e s, input logic pw);
    obs_t o;
    o.ph = s;
    o.pw = pw;
    o.wk = 1'b0;
    o.la = 2'd2;
    o.lb = 2'd2;
    case (s)
      AG:   o.la = 2'd0;
      AY:   o.la = 2'd1;
      BG:   o.lb = 2'd0;
      BY:   o.lb = 2'd1;
      WALK: o.wk = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic cmp(input string name, input obs_t e);
    obs_t a;
    a = {phase, LA, LB, walk, ped_wait};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got phase=%0d LA=%0d LB=%0d walk=%b ped_wait=%b, want phase=%0d LA=%0d LB=%0d walk=%b ped_wait=%b",
               name, a.ph, a.la, a.lb, a.wk, a.pw, e.ph, e.la, e.lb, e.wk, e.pw);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: DUT sampled with no expectation queued", scen);
      end else begin
        cmp(scen, exp_q.pop_front());
      end
    end
  end

  task automatic run(input int n, input state_e s, input logic pw);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick    = 1'b1;
      mon_vld = 1'b1;
      exp_q.push_back(mk(s, pw));
      @(negedge clk);
      tick    = 1'b0;
      mon_vld = 1'b0;
    end
  endtask

  task automatic ped_pulse(input state_e s, input logic pw_after);
    @(negedge clk);
    ped_req = 1'b1;
    mon_vld = 1'b1;
    exp_q.push_back(mk(s, pw_after));
    @(negedge clk);
    ped_req = 1'b0;
    mon_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    mon_vld = 1'b1;
    exp_q.push_back(mk(AG, 1'b0));
    @(negedge clk);
    reset   = 1'b0;
    mon_vld = 1'b0;
  endtask

  task automatic async_reset_check(input string name);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 cmp(name, mk(AG, 1'b0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: stimulus did not complete within time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; tick = 1'b0; TA = 1'b0; TB = 1'b0; ped_req = 1'b0;

    scen = "reset_state";
    do_reset();
    TA = 1'b1; TB = 1'b0;
    scen = "a_hold_no_competition";
    run(50, AG, 1'b0);

    scen = "b_request_seq";
    do_reset();
    TA = 1'b0; TB = 1'b1;
    run(4, AG, 1'b0);
    run(3, AY, 1'b0);
    run(1, AR, 1'b0);
    run(5, BG, 1'b0);

    scen = "both_busy_max_green";
    do_reset();
    TA = 1'b1; TB = 1'b1;
    run(19, AG, 1'b0);
    run(3, AY, 1'b0);
    run(1, AR, 1'b0);
    run(20, BG, 1'b0);
    run(3, BY, 1'b0);
    run(1, BR, 1'b0);
    run(3, AG, 1'b0);

    scen = "async_reset_mid_ay";
    do_reset();
    TA = 1'b0; TB = 1'b1;
    run(4, AG, 1'b0);
    run(2, AY, 1'b0);
    async_reset_check("async_reset_mid_ay");
    scen = "timer_cleared_by_reset";
    run(4, AG, 1'b0);
    run(1, AY, 1'b0);

`ifdef SEMAFORO_PED_EN
    scen = "ped_request_walk";
    do_reset();
    TA = 1'b1; TB = 1'b0;
    ped_pulse(AG, 1'b1);
    run(19, AG, 1'b1);
    run(3, AY, 1'b1);
    run(1, AR, 1'b1);
    ped_req = 1'b1;
    scen = "walk_clear_wins";
    run(8, WALK, 1'b0);
    ped_req = 1'b0;
    scen = "after_walk_b_green";
    run(5, BG, 1'b0);
    run(1, BY, 1'b0);
    ped_pulse(BY, 1'b1);
    run(1, BY, 1'b1);
    async_reset_check("async_reset_mid_by_ped");
    TA = 1'b0; TB = 1'b1;
    scen = "post_reset_timer_zero";
    run(4, AG, 1'b0);
    run(1, AY, 1'b0);
`else
    scen = "ped_ignored";
    do_reset();
    TA = 1'b1; TB = 1'b0;
    ped_pulse(AG, 1'b0);
    run(30, AG, 1'b0);
`endif

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/semaforo_scheduler.md
# semaforo_scheduler

Timed phase scheduler for a two-road intersection (road A, road B) with an optional pedestrian phase. Driven by the system clock plus a one-cycle `tick` time base; sequences green → yellow → all-red → other green using the TA/TB traffic sensors and per-phase minimum/maximum timers. Outputs 2-bit coded light states per road, which downstream decoders expand into lamp drives.

## Interface
- `GREEN_MIN`, 5: minimum green duration, ticks (1..255)
- `GREEN_MAX`, 20: maximum green duration when the other road or a pedestrian is waiting, ticks (GREEN_MIN..255)
- `YELLOW_T`, 3: yellow duration, ticks (1..255)
- `ALLRED_T`, 1: all-red clearance duration, ticks (1..255)
- `WALK_T`, 8: pedestrian walk duration, ticks (1..255)
- `clk` in 1: system clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `tick` in 1: time-base enable, one `clk` cycle wide
- `TA` in 1: traffic present on road A
- `TB` in 1: traffic present on road B
- `ped_req` in 1: pedestrian button, level or pulse
- `LA` out 2: road A light code (0 = green, 1 = yellow, 2 = red; 3 unused)
- `LB` out 2: road B light code, same encoding
- `walk` out 1: pedestrian walk lamp
- `ped_wait` out 1: pedestrian request pending
- `phase` out 3: current state encoding, for debug

## Operation
States and outputs (LA/LB):
- AG: 0/2. AY: 1/2. AR: 2/2 (clearance after A). BG: 2/0. BY: 2/1. BR: 2/2 (clearance after B). WALK: 2/2, `walk`=1.

8-bit `timer` counts ticks spent in the current state. It is cleared on every state change and increments on `tick`, saturating at 255. All exit conditions are evaluated only on cycles with `tick`=1, using the pre-increment `timer` value.

Transitions:
- AG → AY when `timer >= GREEN_MIN-1` and (TB or `ped_wait`) and either !TA or `timer >= GREEN_MAX-1`.
- If neither TB nor `ped_wait` is set, AG holds indefinitely.
- BG → BY uses the same rule with A/B swapped.
- AY → AR and BY → BR when `timer == YELLOW_T-1`.
- AR when `timer == ALLRED_T-1`: go to WALK if `ped_wait`, else BG.
- BR when `timer == ALLRED_T-1`: go to WALK if `ped_wait`, else AG.
- WALK when `timer == WALK_T-1`: go to the green opposite the road that last held green. A 1-bit `next_b` register, set on AR entry and cleared on BR entry, records which road that is.

Pedestrian request:
- `ped_wait` sets on any cycle where `ped_req`=1 and the state is not WALK.
- `ped_wait` clears on the cycle WALK is entered.
- If a state change into WALK and `ped_req`=1 occur in the same cycle, the clear wins.

Reset (asserted at any time, including mid-phase):
- State goes to AG, `timer`=0, `next_b`=0, `ped_wait`=0, `walk`=0.
- LA=0, LB=2, `phase`=AG encoding.

## Timing
- Outputs are Moore outputs: registered state, decoded with no input-to-output combinational path.
- A state change occurs on the `clk` edge that samples a qualifying `tick`. Outputs update in that same edge.
- Resulting phase lengths: yellow lasts exactly YELLOW_T ticks, all-red ALLRED_T ticks, walk WALK_T ticks. Green lasts at least GREEN_MIN ticks and at most GREEN_MAX ticks while it has competition.
- `ped_wait` rises one cycle after `ped_req` is sampled.
- Sensor and button inputs are sampled synchronously and are expected to be pre-synchronised.

## Configuration
- `SEMAFORO_PED_EN` defined: pedestrian logic (WALK state, `ped_wait`, `walk`) is compiled in as described above.
- Undefined: `ped_req` is ignored, `walk` and `ped_wait` are tied 0, and the WALK state and its register are not built. AR always goes to BG and BR always goes to AG.

## Structure
- Shared package `semaforo_pkg`:
  - light codes: GREEN=2'd0, YELLOW=2'd1, RED=2'd2
  - state encodings: AG=0, AY=1, AR=2, BG=3, BY=4, BR=5, WALK=6
  - timer width constant (8)
- One sub-module, `phase_timer`: 8-bit saturating tick counter with synchronous clear and asynchronous reset. The FSM and output decode live in the top.

## Test plan
- Reset → LA=0, LB=2, `walk`=0, `ped_wait`=0. Hold TA=1, TB=0 for 50 ticks → AG persists.
- From reset: TA=0, TB=1 → AY after 5 ticks, AR after 3 more, BG after 1 more. LB=0 at tick 9.
- TA=1 and TB=1 held → A green lasts 20 ticks. Sequence AY(3), AR(1), BG. B green lasts 20 ticks, then the cycle repeats.
- `ped_req` one-cycle pulse during AG with TA=1, TB=0 → `ped_wait`=1 next cycle. AY after 20 ticks, AR(1), WALK for 8 ticks with `walk`=1, then BG. `ped_wait` is 0 from WALK entry.
- `reset` asserted asynchronously mid-BY with `ped_wait`=1 → immediately AG, LA=0, LB=2, `ped_wait`=0, `timer`=0.
- Build without `SEMAFORO_PED_EN`: `ped_req` pulsed, TA=1, TB=0 → `ped_wait`=0, `walk`=0, AG persists.
